// File: rtl/seg7_pkg.sv
// Shared widths, character codes and active-low glyphs ({g,f,e,d,c,b,a}) for the
// seven-segment scan driver.
package seg7_pkg;

    localparam int CODE_W     = 5;
    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;
    localparam int SEG_W      = 7;

    localparam logic [CODE_W-1:0] CODE_H          = 5'h10;
    localparam logic [CODE_W-1:0] CODE_I          = 5'h11;
    localparam logic [CODE_W-1:0] CODE_L          = 5'h12;
    localparam logic [CODE_W-1:0] CODE_N          = 5'h13;
    localparam logic [CODE_W-1:0] CODE_O          = 5'h14;
    localparam logic [CODE_W-1:0] CODE_P          = 5'h15;
    localparam logic [CODE_W-1:0] CODE_R          = 5'h16;
    localparam logic [CODE_W-1:0] CODE_T          = 5'h17;
    localparam logic [CODE_W-1:0] CODE_U          = 5'h18;
    localparam logic [CODE_W-1:0] CODE_Y          = 5'h19;
    localparam logic [CODE_W-1:0] CODE_DASH       = 5'h1A;
    localparam logic [CODE_W-1:0] CODE_UNDERSCORE = 5'h1B;
    localparam logic [CODE_W-1:0] CODE_BLANK      = 5'h1F;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;
    localparam logic [SEG_W-1:0] SEG_H = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_I = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_L = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_N = 7'b0101011;
    localparam logic [SEG_W-1:0] SEG_O = 7'b0100011;
    localparam logic [SEG_W-1:0] SEG_P = 7'b0001100;
    localparam logic [SEG_W-1:0] SEG_R = 7'b0101111;
    localparam logic [SEG_W-1:0] SEG_T = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_U = 7'b1000001;
    localparam logic [SEG_W-1:0] SEG_Y = 7'b0010001;
    localparam logic [SEG_W-1:0] SEG_DASH       = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_UNDERSCORE = 7'b1110111;

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational character-code to active-low glyph decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [SEG_W-1:0]  seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            5'h00: seg_o = SEG_0;
            5'h01: seg_o = SEG_1;
            5'h02: seg_o = SEG_2;
            5'h03: seg_o = SEG_3;
            5'h04: seg_o = SEG_4;
            5'h05: seg_o = SEG_5;
            5'h06: seg_o = SEG_6;
            5'h07: seg_o = SEG_7;
            5'h08: seg_o = SEG_8;
            5'h09: seg_o = SEG_9;
            5'h0A: seg_o = SEG_A;
            5'h0B: seg_o = SEG_B;
            5'h0C: seg_o = SEG_C;
            5'h0D: seg_o = SEG_D;
            5'h0E: seg_o = SEG_E;
            5'h0F: seg_o = SEG_F;
            CODE_H: seg_o = SEG_H;
            CODE_I: seg_o = SEG_I;
            CODE_L: seg_o = SEG_L;
            CODE_N: seg_o = SEG_N;
            CODE_O: seg_o = SEG_O;
            CODE_P: seg_o = SEG_P;
            CODE_R: seg_o = SEG_R;
            CODE_T: seg_o = SEG_T;
            CODE_U: seg_o = SEG_U;
            CODE_Y: seg_o = SEG_Y;
            CODE_DASH:       seg_o = SEG_DASH;
            CODE_UNDERSCORE: seg_o = SEG_UNDERSCORE;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment driver with per-frame snapshot and guard blanking.
// Optional per-digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int BLANK_TICKS  = 2000
`ifdef SEG7_BLINK_EN
   ,parameter int BLINK_FRAMES = 62
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_DIGITS*CODE_W-1:0] display,
    input  logic [NUM_DIGITS-1:0]        dp_en,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]        blink,
`endif
    output logic [NUM_DIGITS-1:0]        an,
    output logic [SEG_W-1:0]             seg,
    output logic                         dp,
    output logic                         frame_done
);

    localparam int TICK_W = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_TICKS);

    logic [TICK_W-1:0]            tick_q, tick_d;
    logic [DIGIT_W-1:0]           digit_q, digit_d;
    logic [NUM_DIGITS*CODE_W-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]        dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]        an_d;
    logic [SEG_W-1:0]             seg_d, glyph;
    logic                         dp_d, frame_done_d;
    logic                         frame_start, frame_end, blank;
    logic [CODE_W-1:0]            code;

`ifdef SEG7_BLINK_EN
    localparam int FCNT_W = $clog2(BLINK_FRAMES + 1);
    logic [NUM_DIGITS-1:0] blink_snap_q, blink_snap_d;
    logic [FCNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                  phase_q, phase_d;
`endif

    seg7_decode u_decode (
        .code_i (code),
        .seg_o  (glyph)
    );

    always_comb begin
        frame_start = (tick_q == '0) && (digit_q == DIGIT_W'(NUM_DIGITS - 1));
        frame_end   = (tick_q == TICK_LAST) && (digit_q == '0);

        // The capture cycle drives from the incoming word so a zero-length guard still shows fresh data.
        snap_d    = frame_start ? display : snap_q;
        dp_snap_d = frame_start ? dp_en   : dp_snap_q;

        tick_d  = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        digit_d = (tick_q == TICK_LAST) ? digit_q - 1'b1 : digit_q;

        code  = snap_d[CODE_W*int'(digit_q) +: CODE_W];
        blank = (tick_q < TICK_BLANK);

`ifdef SEG7_BLINK_EN
        blink_snap_d = frame_start ? blink : blink_snap_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        if (frame_end) begin
            if (frame_cnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        blank = blank || (phase_q && blink_snap_d[digit_q]);
`endif

        an_d         = blank ? '1 : ~(NUM_DIGITS'(1) << digit_q);
        seg_d        = blank ? SEG_BLANK : glyph;
        dp_d         = blank ? 1'b1 : ~dp_snap_d[digit_q];
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q     <= '0;
            digit_q    <= DIGIT_W'(NUM_DIGITS - 1);
            snap_q     <= {NUM_DIGITS{CODE_BLANK}};
            dp_snap_q  <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            digit_q    <= digit_d;
            snap_q     <= snap_d;
            dp_snap_q  <= dp_snap_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            frame_done <= frame_done_d;
        end
    end

`ifdef SEG7_BLINK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_snap_q <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
        end else begin
            blink_snap_q <= blink_snap_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver; reference derives every output from the
// cycle count since reset release and a lit-segment description of each glyph.
module tb_seg7_scan_driver;

    localparam int DT = 4;
    localparam int BT = 1;
    localparam int FL = 8 * DT;
`ifdef SEG7_BLINK_EN
    localparam int BF = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [39:0] display;
    logic [7:0]  dp_en;
    logic [7:0]  blink;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    seg7_scan_driver #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT)
`ifdef SEG7_BLINK_EN
       ,.BLINK_FRAMES (BF)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .display    (display),
        .dp_en      (dp_en),
`ifdef SEG7_BLINK_EN
        .blink      (blink),
`endif
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int          k;
    logic [39:0] m_snap;
    logic [7:0]  m_dp;
    logic [7:0]  m_blink;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
        end
    endtask

    function automatic string lit_segs(input int code);
        case (code)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";   3: return "abcdg";
            4: return "bcfg";     5: return "acdfg";   6: return "acdefg";  7: return "abc";
            8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";  15: return "aefg";
            16: return "bcefg";   17: return "c";      18: return "def";    19: return "ceg";
            20: return "cdeg";    21: return "abefg";  22: return "eg";     23: return "defg";
            24: return "bcdef";   25: return "bcdfg";  26: return "g";      27: return "d";
            default: return "";
        endcase
    endfunction

    function automatic logic [6:0] glyph_of(input int code);
        string s;
        logic [6:0] g;
        s = lit_segs(code);
        g = 7'h7F;
        for (int i = 0; i < s.len(); i++) g[int'(s[i]) - int'("a")] = 1'b0;
        return g;
    endfunction

    // Expected outputs after the edge at which the k-th post-reset state is registered.
    task automatic model_step();
        int tick, digit, frame;
        bit off;
        if (k % FL == 0) begin
            m_snap  = display;
            m_dp    = dp_en;
            m_blink = blink;
        end
        tick  = k % DT;
        digit = 7 - (k / DT) % 8;
        frame = k / FL;
        off   = (tick < BT);
`ifdef SEG7_BLINK_EN
        if (((frame / BF) % 2) == 1 && m_blink[digit]) off = 1'b1;
`else
        if (frame < 0) off = 1'b1;
`endif
        exp_an  = off ? 8'hFF : ~(8'h01 << digit);
        exp_seg = off ? 7'h7F : glyph_of(int'(m_snap[digit*5 +: 5]));
        exp_dp  = off ? 1'b1 : ~m_dp[digit];
        exp_fd  = (k % FL == FL - 1);
        k++;
    endtask

    task automatic randomize_inputs();
        display[39:32] = 8'($urandom);
        display[31:0]  = $urandom;
        dp_en          = 8'($urandom);
        blink          = 8'($urandom);
    endtask

    task automatic run(input int n, input int rnd_pct);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("an", 64'(an), 64'(exp_an));
            check("seg", 64'(seg), 64'(exp_seg));
            check("dp", 64'(dp), 64'(exp_dp));
            check("frame_done", 64'(frame_done), 64'(exp_fd));
            if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) randomize_inputs();
        end
    endtask

    task automatic run_to_frame();
        while (k % FL != 0) run(1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 64'(an), 64'(8'hFF));
        check({tag, "_seg"}, 64'(seg), 64'(7'h7F));
        check({tag, "_dp"}, 64'(dp), 64'(1'b1));
        check({tag, "_fd"}, 64'(frame_done), 64'(1'b0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        k = 0;
    endtask

    logic [39:0] scan_codes;
    bit found;

    initial begin
        display = '1;
        dp_en   = '0;
        blink   = '0;
        k       = 0;
        for (int i = 0; i < 8; i++) scan_codes[i*5 +: 5] = 5'(i);

        // reset held, then release into a blank snapshot
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        release_reset();
        run(DT + 2, 0);

        // scan order with decimal point on digit 0
        run_to_frame();
        display = scan_codes;
        dp_en   = 8'h01;
        run(2 * FL, 0);

        // snapshot: the word changes mid-frame but only the next frame shows it
        run_to_frame();
        display = {8{5'h08}};
        run(12, 0);
        display = '0;
        run(2 * FL - 12, 0);

        // "bAd" on AN5..AN3
        run_to_frame();
        display = {5'h1F, 5'h1F, 5'h0B, 5'h0A, 5'h0D, 5'h1F, 5'h1F, 5'h1F};
        dp_en   = 8'h00;
        run(FL, 0);

`ifdef SEG7_BLINK_EN
        run_to_frame();
        display = scan_codes;
        blink   = 8'h80;
        run(6 * FL, 0);
`endif

        // randomized traffic with inputs changing at arbitrary cycles
        run(8 * FL, 12);

        // asynchronous reset while digit 3 is lit
        found = 1'b0;
        for (int i = 0; i < 2 * FL && !found; i++) begin
            run(1, 0);
            if (exp_an == 8'hF7) found = 1'b1;
        end
        check("reach_digit3", 64'(found), 64'(1'b1));
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        display = scan_codes;
        dp_en   = 8'h10;
        blink   = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        release_reset();
        run(FL + DT, 0);

        run(4 * FL, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (k=%0d)", k);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the ALU/application mux and consumes the 40-bit `display` word: eight 5-bit character codes. Each frame it snapshots the word, scans the digits with a guard (ghost-blanking) interval, decodes each code to active-low segments, and flags frame completion.

## Interface
Parameters:
- `DIGIT_TICKS`, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- `BLANK_TICKS`, 2000: cycles at the start of each slot with all anodes off; must be < `DIGIT_TICKS`.
- `BLINK_FRAMES`, 62: frames per blink phase (only with `SEG7_BLINK_EN`).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `display` in 40: character codes; [39:35] is the leftmost digit (AN7), [4:0] the rightmost (AN0).
- `dp_en` in 8: decimal-point enables, active-high; bit i maps to digit i.
- `blink` in 8: per-digit blink enables, active-high; only with `SEG7_BLINK_EN`.
- `an` out 8: anode enables, active-low.
- `seg` out 7: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point, active-low.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- State:
  - `tick`, 0..DIGIT_TICKS-1.
  - `digit`, 7..0, scanned descending.
  - `snap`: the 40-bit snapshot.
  - `dp_snap` and `blink_snap`: the sampled enable masks.
  - blink `phase` and frame counter, only with the macro.
- Reset values:
  - tick=0, digit=7.
  - snap = all 5'h1F; dp_snap=0.
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
- Frame start: every cycle with tick==0 and digit==7, including the first cycle after reset release. On that cycle `display`, `dp_en` and `blink` are loaded into the snapshot registers. Inputs do not reach the outputs at any other time, so the display never tears.
- Counting: tick increments each cycle. At DIGIT_TICKS-1, tick wraps to 0 and digit decrements; digit 0 wraps to 7.
- Guard interval: while tick < BLANK_TICKS, an=8'hFF, seg=7'h7F and dp=1.
- Drive (otherwise):
  - an has only bit `digit` low.
  - seg = decode(snap[digit*5+4 : digit*5]).
  - dp = ~dp_snap[digit].
- Decode:
  - 0x00–0x0F: hex glyphs 0–F (lowercase b and d). Examples: 0→7'b1000000, 8→7'b0000000, A→7'b0001000, b→7'b0000011, d→7'b0100001.
  - 0x10 H, 0x11 i, 0x12 L, 0x13 n, 0x14 o, 0x15 P, 0x16 r, 0x17 t, 0x18 U, 0x19 y, 0x1A '-', 0x1B '_'.
  - 0x1C–0x1F: blank (7'h7F).
- frame_done is asserted for the cycle after tick==DIGIT_TICKS-1 with digit==0.
- Reset mid-scan: all outputs go to their reset values immediately (asynchronous), and the scan restarts at digit 7 with a fresh snapshot.

## Timing
- `an`, `seg`, `dp` and `frame_done` are registered. The output in cycle n+1 reflects the state (tick, digit, snapshot) in cycle n, i.e. 1-cycle latency.
- Slot length is DIGIT_TICKS cycles; frame length is 8·DIGIT_TICKS cycles.
- A `display` change becomes visible starting at the next frame-start capture. Worst-case latency is 8·DIGIT_TICKS + BLANK_TICKS + 1 cycles.
- `an` never has more than one bit low, and it is all-high for exactly BLANK_TICKS cycles at each slot boundary.

## Configuration
- `SEG7_BLINK_EN` defined:
  - Adds the `blink` port, a frame counter and the `phase` bit (reset 0).
  - `phase` toggles after every BLINK_FRAMES frame_done pulses.
  - While phase=1, digits with blink_snap[i]=1 are forced blank (an bit high, seg=7'h7F, dp=1) for their whole slot.
- Undefined: no `blink` port, no counter; digits never blank outside the guard interval.

## Structure
- Package `seg7_pkg`:
  - Code width (5) and digit count (8).
  - Character-code constants: CODE_BLANK=5'h1F, CODE_H=5'h10 … CODE_UNDERSCORE=5'h1B.
  - Active-low glyph constants (SEG_BLANK=7'h7F).
- Sub-module `seg7_decode`: purely combinational, 5-bit code → 7-bit active-low glyph; instantiated once.

## Test plan
All scenarios use DIGIT_TICKS=4 and BLANK_TICKS=1.
- **Reset.** Hold reset low, then release. During reset: an=FF, seg=7F, dp=1. One cycle after release: an=FF (guard). Then an=7F, seg=7F (blank snapshot captured from a blank `display`).
- **Scan order.** display = codes 7,6,…,0 with dp_en=8'h01. Verify:
  - Anodes step 7F, BF, … FE, with an=FF for 1 cycle before each.
  - Digit 0 shows seg=7'b1000000 and dp=0.
  - frame_done pulses every 32 cycles.
- **Snapshot.** Change display from all 8 to all 0 mid-frame. The remaining digits of that frame still show 7'b0000000; the next frame shows 7'b1000000.
- **Codes.** display = {1F,1F,0B,0A,0D,1F,1F,1F} shows "bAd" on AN5–AN3: 0000011, 0001000, 0100001.
- **Async reset mid-scan.** Assert reset while digit 3 is lit. `an` goes to FF in the same cycle, and the scan restarts at AN7.
- **Blink (`SEG7_BLINK_EN`, BLINK_FRAMES=2).** With blink=8'h80: AN7 is lit for frames 0–1, dark for frames 2–3, lit for frames 4–5.
